shift_unit: RTL

Multicycle shifter that consumes the SHIFTER_control / M_SHIFTER command stream issued by the ALU control decoder. It executes the commands load, shift left, shift right logical and shift right arithmetic. A shift runs bit-serially, one position per cycle, and the block reports busy/done back to the control unit. The result feeds the ALUOut mux on the shifter input (M_ALUOut_control = 010).

---
 rtl/shift_unit_pkg.sv | 51 +++++
 rtl/shift_unit_step.sv | 47 ++++
 rtl/shift_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shift_unit_pkg.sv
// ============================================================================
// Module      : shift_unit_pkg
// Description : Command codes, source codes, state and direction types shared
//               by the multicycle shifter and the ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_unit_pkg;

    typedef enum logic [2:0] {
        SH_NOP  = 3'b000,
        SH_LOAD = 3'b001,
        SH_SHL  = 3'b010,
        SH_SHR  = 3'b011,
        SH_SRA  = 3'b100
    } sh_cmd_e;

    localparam logic c_M_SHIFTER_REG = 1'b0;
    localparam logic c_M_SHIFTER_LUI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOADED   = 2'd1,
        ST_SHIFTING = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_SHL = 2'd0,
        DIR_SHR = 2'd1,
        DIR_SRA = 2'd2
    } dir_e;

    localparam int c_LUI_SHAMT_DEFAULT = 16;

    function automatic logic is_shift_cmd(input logic [2:0] cmd);
        return (cmd == SH_SHL) || (cmd == SH_SHR) || (cmd == SH_SRA);
    endfunction

    function automatic dir_e cmd_to_dir(input logic [2:0] cmd);
        dir_e dir;
        dir = DIR_SHL;
        if (cmd == SH_SHR) dir = DIR_SHR;
        if (cmd == SH_SRA) dir = DIR_SRA;
        return dir;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_unit_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational shift stage: one position per use, or a full
//               barrel shift by amt_i when SHIFTER_BARREL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  dir_e               dir_i,
`ifdef SHIFTER_BARREL_EN
    input  logic [SHAMT_W-1:0] amt_i,
`endif
    input  logic [WIDTH-1:0]   data_i,
    output logic [WIDTH-1:0]   data_o
);

`ifdef SHIFTER_BARREL_EN
    always_comb begin
        data_o = data_i;
        case (dir_i)
            DIR_SHL: data_o = data_i << amt_i;
            DIR_SHR: data_o = data_i >> amt_i;
            DIR_SRA: data_o = $unsigned($signed(data_i) >>> amt_i);
            default: data_o = data_i;
        endcase
    end
`else
    always_comb begin
        data_o = data_i;
        case (dir_i)
            DIR_SHL: data_o = {data_i[WIDTH-2:0], 1'b0};
            DIR_SHR: data_o = {1'b0, data_i[WIDTH-1:1]};
            DIR_SRA: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            default: data_o = data_i;
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: rtl/shift_unit.sv
// ============================================================================
// Module      : shift_unit
// Description : Multicycle load/shl/shr/sra shifter with busy/done handshake.
//               Define SHIFTER_BARREL_EN for single-cycle barrel shifting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = 5,
    parameter int LUI_SHAMT = c_LUI_SHAMT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         SHIFTER_control,
    input  logic               M_SHIFTER,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [15:0]        imm16,
    input  logic [SHAMT_W-1:0] shamt_in,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [SHAMT_W-1:0]   amt_q, amt_d;
    logic [WIDTH-1:0]     w_step_out;
    logic                 w_is_load;
    logic                 w_is_shift;
    dir_e                 w_cmd_dir;

    assign w_is_load  = (SHIFTER_control == SH_LOAD);
    assign w_is_shift = is_shift_cmd(SHIFTER_control);
    assign w_cmd_dir  = cmd_to_dir(SHIFTER_control);

`ifdef SHIFTER_BARREL_EN
    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .dir_i  (w_cmd_dir),
        .amt_i  (amt_q),
        .data_i (result_q),
        .data_o (w_step_out)
    );
`else
    // Direction is latched at acceptance so later commands cannot disturb it.
    dir_e                 dir_q, dir_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .dir_i  (dir_q),
        .data_i (result_q),
        .data_o (w_step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q <= DIR_SHL;
            cnt_q <= '0;
        end else begin
            dir_q <= dir_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            amt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            amt_q    <= amt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        amt_d    = amt_q;
`ifndef SHIFTER_BARREL_EN
        dir_d    = dir_q;
        cnt_d    = cnt_q;
`endif
        if (state_q == ST_SHIFTING) begin
`ifndef SHIFTER_BARREL_EN
            result_d = w_step_out;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
`endif
        end else begin
            // DONE falls back to LOADED unless a new command overrides it.
            if (state_q == ST_DONE) state_d = ST_LOADED;
            if (w_is_load) begin
                state_d = ST_LOADED;
                if (M_SHIFTER == c_M_SHIFTER_LUI) begin
                    result_d = {{(WIDTH-16){1'b0}}, imm16};
                    amt_d    = SHAMT_W'(LUI_SHAMT);
                end else begin
                    result_d = operand_a;
                    amt_d    = shamt_in;
                end
            end else if (w_is_shift && (state_q != ST_IDLE)) begin
`ifdef SHIFTER_BARREL_EN
                result_d = w_step_out;
                state_d  = ST_DONE;
`else
                dir_d = w_cmd_dir;
                cnt_d = amt_q;
                state_d = (amt_q == '0) ? ST_DONE : ST_SHIFTING;
`endif
            end
        end
    end

    assign result = result_q;
    assign busy   = (state_q == ST_SHIFTING);
    assign done   = (state_q == ST_DONE);

endmodule

`default_nettype wire
